// File: rtl/aes_out_block_fifo.sv
// Output stage for the AES core: buffers up to DEPTH cipher blocks and streams
// the head block out byte 0 first, with a random-access peek into the head block.
module aes_out_block_fifo #(
    parameter  int BLOCK_W = 128,
    parameter  int BYTE_W  = 8,
    parameter  int DEPTH   = 4,
    localparam int NB      = BLOCK_W / BYTE_W,
    localparam int AW      = $clog2(NB),
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int PW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [BYTE_W-1:0]  out_byte,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    input  logic [AW-1:0]      peek_addr,
    output logic [BYTE_W-1:0]  peek_data,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty
);

    logic [NB-1:0][BYTE_W-1:0] mem [DEPTH];
    logic [NB-1:0][BYTE_W-1:0] head;
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             rd_ptr;
    logic [AW-1:0]             byte_idx;
    logic                      push;
    logic                      beat;
    logic                      last_byte;
    logic                      pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = ~full;
    assign out_valid = ~empty;

    // flush wins over a same-cycle push or beat, so both are masked here
    assign push      = in_valid & in_ready & ~flush;
    assign beat      = out_valid & out_ready & ~flush;
    assign last_byte = (byte_idx == AW'(NB - 1));
    assign pop       = beat & last_byte;

    assign head      = mem[rd_ptr];
    assign out_byte  = empty ? '0 : head[byte_idx];
    assign out_last  = ~empty & last_byte;
    assign peek_data = empty ? '0 : head[peek_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            byte_idx <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (beat) begin
                byte_idx <= last_byte ? '0 : byte_idx + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_aes_out_block_fifo.sv
// Bench for aes_out_block_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_aes_out_block_fifo;

    localparam int BLOCK_W = 128;
    localparam int BYTE_W  = 8;
    localparam int DEPTH   = 4;
    localparam int NB      = BLOCK_W / BYTE_W;
    localparam int AW      = $clog2(NB);
    localparam int CW      = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               flush = 1'b0;
    logic [BLOCK_W-1:0] in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [BYTE_W-1:0]  out_byte;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               out_last;
    logic [AW-1:0]      peek_addr = '0;
    logic [BYTE_W-1:0]  peek_data;
    logic [CW-1:0]      count;
    logic               full;
    logic               empty;

    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 1'b0;

    aes_out_block_fifo #(.BLOCK_W(BLOCK_W), .BYTE_W(BYTE_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_byte(out_byte), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .peek_addr(peek_addr),
        .peek_data(peek_data), .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of whole blocks plus the read position in the head block
    logic [BLOCK_W-1:0] mq[$];
    int                 mbidx = 0;

    always @(posedge clk) begin
        bit do_push;
        if (rst || flush) begin
            mq.delete();
            mbidx = 0;
        end else begin
            do_push = in_valid && (mq.size() < DEPTH);
            if (mq.size() > 0 && out_ready) begin
                if (mbidx == NB - 1) begin
                    void'(mq.pop_front());
                    mbidx = 0;
                end else begin
                    mbidx++;
                end
            end
            if (do_push) mq.push_back(in_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BYTE_W-1:0] model_byte(input int idx);
        logic [BLOCK_W-1:0] h;
        if (mq.size() == 0) return '0;
        h = mq[0];
        return h[BYTE_W*idx +: BYTE_W];
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            chk("count",     32'(count),     32'(mq.size()));
            chk("full",      32'(full),      32'(mq.size() == DEPTH));
            chk("empty",     32'(empty),     32'(mq.size() == 0));
            chk("in_ready",  32'(in_ready),  32'(mq.size() != DEPTH));
            chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("out_byte",  32'(out_byte),  32'(model_byte(mbidx)));
            chk("out_last",  32'(out_last),  32'(mq.size() != 0 && mbidx == NB - 1));
            chk("peek_data", 32'(peek_data), 32'(model_byte(int'(peek_addr))));
        end
    end

    // Inputs change 2 time units after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [BLOCK_W-1:0] mkblk(input int k);
        logic [BLOCK_W-1:0] b;
        for (int i = 0; i < NB; i++) b[BYTE_W*i +: BYTE_W] = BYTE_W'(k * 16 + i);
        return b;
    endfunction

    task automatic drain(input int beats);
        out_ready = 1'b1;
        for (int i = 0; i < beats; i++) tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [BLOCK_W-1:0] b;

        tick(); tick();
        rst = 1'b0;
        checking = 1'b1;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_byte", 32'(out_byte), 0);
        chk("rst_peek", 32'(peek_data), 0);

        // single block, byte 0 first, out_valid the cycle after the push edge
        tick();
        in_data = 128'h0F0E0D0C0B0A09080706050403020100;
        in_valid = 1'b1;
        out_ready = 1'b1;
        chk("lat_pre_valid", 32'(out_valid), 0);
        tick();
        in_valid = 1'b0;
        chk("lat_valid", 32'(out_valid), 1);
        for (int i = 0; i < NB; i++) begin
            chk("single_byte", 32'(out_byte), 32'(i));
            chk("single_last", 32'(out_last), 32'(i == NB - 1));
            tick();
        end
        out_ready = 1'b0;
        chk("single_empty", 32'(empty), 1);

        // fill past capacity with the consumer stalled
        for (int k = 1; k <= 5; k++) begin
            in_data = mkblk(k);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("fill_full", 32'(full), 1);
        chk("fill_in_ready", 32'(in_ready), 0);
        chk("fill_count", 32'(count), 4);
        out_ready = 1'b1;
        for (int i = 0; i < 4 * NB; i++) begin
            chk("fill_order", 32'(out_byte), 32'(8'(((i / NB) + 1) * 16 + (i % NB))));
            tick();
        end
        out_ready = 1'b0;
        chk("fill_drained", 32'(empty), 1);

        // push on the same edge as the last beat of the head block
        in_valid = 1'b1; in_data = mkblk(6); tick();
        in_data = mkblk(7); tick();
        in_valid = 1'b0;
        chk("simul_count_pre", 32'(count), 2);
        out_ready = 1'b1;
        for (int i = 0; i < NB - 1; i++) tick();
        in_valid = 1'b1; in_data = mkblk(8);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("simul_count", 32'(count), 2);
        chk("simul_next", 32'(out_byte), 32'h70);
        drain(2 * NB);
        chk("simul_empty", 32'(empty), 1);

        // peek sweep with the stream stalled
        for (int i = 0; i < NB; i++) b[BYTE_W*i +: BYTE_W] = BYTE_W'(8'hA0 + i);
        in_valid = 1'b1; in_data = b; tick();
        in_valid = 1'b0;
        for (int i = 0; i < NB; i++) begin
            peek_addr = AW'(i);
            #1;
            chk("peek_data", 32'(peek_data), 32'(8'hA0 + i));
            tick();
        end
        chk("peek_count", 32'(count), 1);
        chk("peek_head", 32'(out_byte), 32'hA0);
        drain(NB);

        // flush 7 beats into a block with a push in the same cycle
        in_valid = 1'b1; in_data = mkblk(9); tick();
        in_valid = 1'b0;
        drain(7);
        chk("flush_mid", 32'(out_byte), 32'h97);
        flush = 1'b1; in_valid = 1'b1; in_data = mkblk(10); out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush_count", 32'(count), 0);
        chk("flush_empty", 32'(empty), 1);
        in_valid = 1'b1; in_data = mkblk(11); tick();
        in_valid = 1'b0;
        chk("flush_restart", 32'(out_byte), 32'hB0);
        drain(NB);

        // randomized traffic, checked by the per-cycle compare
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 99) == 0);
            peek_addr = AW'($urandom_range(0, NB - 1));
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        // reset mid-stream
        in_valid = 1'b1; in_data = mkblk(12); tick(); tick();
        in_valid = 1'b0;
        drain(5);
        rst = 1'b1; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst2_count", 32'(count), 0);
        chk("rst2_empty", 32'(empty), 1);
        chk("rst2_in_ready", 32'(in_ready), 1);
        chk("rst2_out_valid", 32'(out_valid), 0);
        chk("rst2_out_byte", 32'(out_byte), 0);
        tick(); tick();

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
